sfp_port_mgr: RTL and testbench

SFP_PORT_MGR -- requirements
Module: sfp_port_mgr

---
 rtl/sfp_port_mgr_pkg.sv | 28 ++
 rtl/sfp_pin_debounce.sv | 72 +++++++
 rtl/sfp_port_mgr.sv | 108 ++++++++++
 tb/tb_sfp_port_mgr.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfp_port_mgr_pkg.sv
// Shared definitions for the SFP port manager: debounce FSM encoding,
// reset values, parameter limits and the LED drive helper.
package sfp_port_mgr_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    CONFIRM = 1'b1
  } deb_state_t;

  localparam int MIN_PORTS       = 1;
  localparam int MAX_PORTS       = 16;
  localparam int MIN_DEB_SAMPLES = 2;
  localparam int MAX_DEB_SAMPLES = 15;

  // Wide enough to count up to MAX_DEB_SAMPLES
  localparam int CNT_W = 4;

  localparam logic STATUS_RST = 1'b1;
  localparam logic INT_RST    = 1'b0;
  localparam logic INT_N_RST  = 1'b1;
  localparam logic LED_RST    = 1'b0;
  localparam logic TXDIS_RST  = 1'b1;

  function automatic logic led_drive(input logic link, input logic act, input logic phase);
    return link & (~act | phase);
  endfunction

endpackage

// File: rtl/sfp_pin_debounce.sv
// One SFP status pin: 2-flop synchroniser followed by a STABLE/CONFIRM
// debounce FSM that flips the status after DEB_SAMPLES differing samples.
module sfp_pin_debounce
  import sfp_port_mgr_pkg::*;
#(
  parameter int DEB_SAMPLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_tick,
  input  logic pin,
  output logic status,
  output logic change
);

  logic [1:0]       sync_q;
  deb_state_t       state;
  logic [CNT_W-1:0] count;
  logic             pin_sync;

  assign pin_sync = sync_q[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= {2{STATUS_RST}};
    end else begin
      sync_q <= {sync_q[0], pin};
    end
  end

  // The sample that would bring count to DEB_SAMPLES flips the status instead
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= STABLE;
      count  <= '0;
      status <= STATUS_RST;
      change <= 1'b0;
    end else begin
      change <= 1'b0;
      if (sample_tick) begin
        case (state)
          STABLE: begin
            if (pin_sync != status) begin
              count <= CNT_W'(1);
              state <= CONFIRM;
            end
          end
          CONFIRM: begin
            if (pin_sync != status) begin
              if (count == CNT_W'(DEB_SAMPLES - 1)) begin
                status <= ~status;
                change <= 1'b1;
                count  <= '0;
                state  <= STABLE;
              end else begin
                count <= count + CNT_W'(1);
              end
            end else begin
              count <= '0;
              state <= STABLE;
            end
          end
          default: begin
            count <= '0;
            state <= STABLE;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/sfp_port_mgr.sv
// SFP cage manager: debounced ABS/LOS status, sticky interrupts, LEDs,
// I2C SCL steering and TX disable. Macro SFP_AUTO_TXDIS_EN forces TX off for absent cages.
module sfp_port_mgr
  import sfp_port_mgr_pkg::*;
#(
  parameter int NUM_PORTS   = 8,
  parameter int DEB_SAMPLES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 blink_tick,
  input  logic [NUM_PORTS-1:0] sfp_abs_pin,
  input  logic [NUM_PORTS-1:0] sfp_los_pin,
  input  logic [1:0]           int_mask,
  input  logic                 rd_abs_int,
  input  logic                 rd_los_int,
  input  logic [NUM_PORTS-1:0] led_link,
  input  logic [NUM_PORTS-1:0] led_act,
  input  logic [NUM_PORTS-1:0] txdis_reg,
  input  logic [3:0]           iic_sel,
  input  logic                 scl_in,
  output logic [NUM_PORTS-1:0] abs_status,
  output logic [NUM_PORTS-1:0] los_status,
  output logic [NUM_PORTS-1:0] abs_int,
  output logic [NUM_PORTS-1:0] los_int,
  output logic [NUM_PORTS-1:0] led,
  output logic [NUM_PORTS-1:0] txdis,
  output logic [NUM_PORTS-1:0] scl_out,
  output logic [NUM_PORTS-1:0] scl_oe,
  output logic                 int_n
);

  logic [NUM_PORTS-1:0] abs_change;
  logic [NUM_PORTS-1:0] los_change;
  logic                 blink_phase;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    sfp_pin_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_abs (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample_tick (sample_tick),
      .pin         (sfp_abs_pin[g]),
      .status      (abs_status[g]),
      .change      (abs_change[g])
    );
    sfp_pin_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_los (
      .clk         (clk),
      .rst_n       (rst_n),
      .sample_tick (sample_tick),
      .pin         (sfp_los_pin[g]),
      .status      (los_status[g]),
      .change      (los_change[g])
    );
  end

  // A change arriving with a read-clear survives because it is ORed after the clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      abs_int <= {NUM_PORTS{INT_RST}};
      los_int <= {NUM_PORTS{INT_RST}};
      int_n   <= INT_N_RST;
    end else begin
      abs_int <= (rd_abs_int ? '0 : abs_int) | abs_change;
      los_int <= (rd_los_int ? '0 : los_int) | los_change;
      int_n   <= ~((|abs_int & ~int_mask[0]) | (|los_int & ~int_mask[1]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_phase <= 1'b0;
      led         <= {NUM_PORTS{LED_RST}};
    end else begin
      if (blink_tick) begin
        blink_phase <= ~blink_phase;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        led[i] <= led_drive(led_link[i], led_act[i], blink_phase);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txdis <= {NUM_PORTS{TXDIS_RST}};
    end else begin
`ifdef SFP_AUTO_TXDIS_EN
      txdis <= txdis_reg | abs_status;
`else
      txdis <= txdis_reg;
`endif
    end
  end

  // Selections beyond the last port match no index and leave every scl_oe low
  always_comb begin
    scl_oe = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (iic_sel == 4'(i)) begin
        scl_oe[i] = 1'b1;
      end
    end
  end

  assign scl_out = {NUM_PORTS{scl_in}};

endmodule

// File: tb/tb_sfp_port_mgr.sv
// Directed bench for sfp_port_mgr (NUM_PORTS=8, DEB_SAMPLES=3); expected
// TX-disable values follow whether SFP_AUTO_TXDIS_EN is defined.
module tb_sfp_port_mgr;

  localparam int NP = 8;
  localparam int DS = 3;
`ifdef SFP_AUTO_TXDIS_EN
  localparam bit AUTO_TXDIS = 1'b1;
`else
  localparam bit AUTO_TXDIS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sample_tick = 1'b0;
  logic          blink_tick = 1'b0;
  logic [NP-1:0] sfp_abs_pin = '1;
  logic [NP-1:0] sfp_los_pin = '1;
  logic [1:0]    int_mask = 2'b00;
  logic          rd_abs_int = 1'b0;
  logic          rd_los_int = 1'b0;
  logic [NP-1:0] led_link = '0;
  logic [NP-1:0] led_act = '0;
  logic [NP-1:0] txdis_reg = '0;
  logic [3:0]    iic_sel = 4'h0;
  logic          scl_in = 1'b0;
  logic [NP-1:0] abs_status, los_status, abs_int, los_int, led, txdis, scl_out, scl_oe;
  logic          int_n;

  int vectors = 0;
  int miscompares = 0;

  sfp_port_mgr #(.NUM_PORTS(NP), .DEB_SAMPLES(DS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .blink_tick  (blink_tick),
    .sfp_abs_pin (sfp_abs_pin),
    .sfp_los_pin (sfp_los_pin),
    .int_mask    (int_mask),
    .rd_abs_int  (rd_abs_int),
    .rd_los_int  (rd_los_int),
    .led_link    (led_link),
    .led_act     (led_act),
    .txdis_reg   (txdis_reg),
    .iic_sel     (iic_sel),
    .scl_in      (scl_in),
    .abs_status  (abs_status),
    .los_status  (los_status),
    .abs_int     (abs_int),
    .los_int     (los_int),
    .led         (led),
    .txdis       (txdis),
    .scl_out     (scl_out),
    .scl_oe      (scl_oe),
    .int_n       (int_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NP-1:0] link;
    logic [NP-1:0] act;
    logic [NP-1:0] txreg;
    logic [3:0]    sel;
    logic          scl;
    logic [NP-1:0] exp_led;
    logic [NP-1:0] exp_oe;
    logic [NP-1:0] exp_out;
  } vec_t;

  vec_t tbl[6];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a negedge; the strobe covers exactly one rising edge
  task automatic pulse_sample();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic apply_stimulus(input vec_t v);
    led_link  = v.link;
    led_act   = v.act;
    txdis_reg = v.txreg;
    iic_sel   = v.sel;
    scl_in    = v.scl;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic exp_phase;
    logic prev_led1;
    int   toggles;

    tbl[0] = '{8'h00, 8'h00, 8'h00, 4'h0, 1'b1, 8'h00, 8'h01, 8'hFF};
    tbl[1] = '{8'hFF, 8'h0F, 8'hA5, 4'h7, 1'b0, 8'hF0, 8'h80, 8'h00};
    tbl[2] = '{8'h03, 8'h02, 8'h3C, 4'h3, 1'b1, 8'h01, 8'h08, 8'hFF};
    tbl[3] = '{8'hAA, 8'h00, 8'hFF, 4'h8, 1'b1, 8'hAA, 8'h00, 8'hFF};
    tbl[4] = '{8'h55, 8'h55, 8'h00, 4'hF, 1'b0, 8'h00, 8'h00, 8'h00};
    tbl[5] = '{8'h81, 8'h01, 8'h81, 4'h9, 1'b1, 8'h80, 8'h00, 8'hFF};

    // Reset values
    rst_n = 1'b0;
    wait_clks(4);
    check_output("rst_abs_status", 32'(abs_status), 32'hFF);
    check_output("rst_los_status", 32'(los_status), 32'hFF);
    check_output("rst_abs_int", 32'(abs_int), 32'h00);
    check_output("rst_los_int", 32'(los_int), 32'h00);
    check_output("rst_int_n", 32'(int_n), 32'h1);
    check_output("rst_led", 32'(led), 32'h00);
    check_output("rst_txdis", 32'(txdis), 32'hFF);
    rst_n = 1'b1;
    wait_clks(2);

    // Static LED / SCL / TX-disable vectors, blink_phase still 0, all cages absent
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(tbl[i]);
      wait_clks(1);
      check_output($sformatf("tbl%0d_led", i), 32'(led), 32'(tbl[i].exp_led));
      check_output($sformatf("tbl%0d_scl_oe", i), 32'(scl_oe), 32'(tbl[i].exp_oe));
      check_output($sformatf("tbl%0d_scl_out", i), 32'(scl_out), 32'(tbl[i].exp_out));
      check_output($sformatf("tbl%0d_txdis", i), 32'(txdis),
                   32'(tbl[i].txreg | (AUTO_TXDIS ? 8'hFF : 8'h00)));
    end
    led_link = '0; led_act = '0; txdis_reg = '0; iic_sel = 4'h0;

    // Debounce accept on abs pin 2
    sfp_abs_pin = 8'hFB;
    wait_clks(3);
    pulse_sample();
    pulse_sample();
    check_output("accept_before_3rd", 32'(abs_status), 32'hFF);
    pulse_sample();
    check_output("accept_status", 32'(abs_status), 32'hFB);
    wait_clks(1);
    check_output("accept_abs_int", 32'(abs_int), 32'h04);
    wait_clks(1);
    check_output("accept_int_n", 32'(int_n), 32'h0);

    // Read-to-clear
    rd_abs_int = 1'b1;
    wait_clks(1);
    rd_abs_int = 1'b0;
    check_output("rdclr_abs_int", 32'(abs_int), 32'h00);
    wait_clks(1);
    check_output("rdclr_int_n", 32'(int_n), 32'h1);

    // Glitch reject on los pin 5, then a fresh 2-sample glitch proves count restarted
    sfp_los_pin = 8'hDF;
    wait_clks(3);
    pulse_sample();
    pulse_sample();
    sfp_los_pin = 8'hFF;
    wait_clks(3);
    pulse_sample();
    check_output("glitch_los_status", 32'(los_status), 32'hFF);
    sfp_los_pin = 8'hDF;
    wait_clks(3);
    pulse_sample();
    pulse_sample();
    check_output("glitch_restart_status", 32'(los_status), 32'hFF);
    sfp_los_pin = 8'hFF;
    wait_clks(3);
    pulse_sample();
    wait_clks(1);
    check_output("glitch_los_int", 32'(los_int), 32'h00);
    check_output("glitch_int_n", 32'(int_n), 32'h1);

    // Clear/set collision: pending bit 2, port 0 changes in the read-clear cycle
    sfp_abs_pin = 8'hFF;
    wait_clks(3);
    repeat (3) pulse_sample();
    wait_clks(2);
    check_output("coll_pre_abs_int", 32'(abs_int), 32'h04);
    check_output("coll_pre_int_n", 32'(int_n), 32'h0);
    sfp_abs_pin = 8'hFE;
    wait_clks(3);
    repeat (3) pulse_sample();
    check_output("coll_abs_status", 32'(abs_status), 32'hFE);
    rd_abs_int = 1'b1;
    wait_clks(1);
    rd_abs_int = 1'b0;
    check_output("coll_abs_int", 32'(abs_int), 32'h01);
    check_output("coll_int_n_a", 32'(int_n), 32'h0);
    wait_clks(1);
    check_output("coll_int_n_b", 32'(int_n), 32'h0);

    // Masking gates only int_n
    int_mask = 2'b01;
    rd_abs_int = 1'b1;
    wait_clks(1);
    rd_abs_int = 1'b0;
    sfp_abs_pin = 8'hEE;
    wait_clks(3);
    repeat (3) pulse_sample();
    wait_clks(3);
    check_output("mask_abs_int", 32'(abs_int), 32'h10);
    check_output("mask_int_n", 32'(int_n), 32'h1);
    int_mask = 2'b00;
    wait_clks(1);
    check_output("unmask_int_n", 32'(int_n), 32'h0);

    // Reset in the middle of a confirmation
    sfp_abs_pin = 8'h00;
    wait_clks(3);
    pulse_sample();
    pulse_sample();
    rst_n = 1'b0;
    wait_clks(1);
    rst_n = 1'b1;
    check_output("midrst_abs_status", 32'(abs_status), 32'hFF);
    check_output("midrst_abs_int", 32'(abs_int), 32'h00);
    wait_clks(3);
    pulse_sample();
    pulse_sample();
    check_output("midrst_restart_status", 32'(abs_status), 32'hFF);
    check_output("midrst_no_int", 32'(abs_int), 32'h00);
    pulse_sample();
    check_output("midrst_accept_status", 32'(abs_status), 32'h00);
    wait_clks(1);
    check_output("midrst_accept_int", 32'(abs_int), 32'hFF);

    // Only port 3 absent, software TX-disable off
    txdis_reg = 8'h00;
    sfp_abs_pin = 8'h08;
    wait_clks(3);
    repeat (3) pulse_sample();
    check_output("txdis_abs_status", 32'(abs_status), 32'h08);
    wait_clks(1);
    check_output("txdis_auto", 32'(txdis), AUTO_TXDIS ? 32'h08 : 32'h00);

    // LED blink and SCL steering
    led_link = 8'h03;
    led_act  = 8'h02;
    wait_clks(2);
    check_output("led_initial", 32'(led), 32'h01);
    exp_phase = 1'b0;
    prev_led1 = led[1];
    toggles = 0;
    for (int k = 0; k < 4; k++) begin
      blink_tick = 1'b1;
      wait_clks(1);
      blink_tick = 1'b0;
      wait_clks(1);
      exp_phase = ~exp_phase;
      check_output($sformatf("blink%0d_led0", k), 32'(led[0]), 32'h1);
      check_output($sformatf("blink%0d_led1", k), 32'(led[1]), 32'(exp_phase));
      if (led[1] != prev_led1) toggles++;
      prev_led1 = led[1];
    end
    check_output("blink_toggles", 32'(toggles), 32'd4);
    iic_sel = 4'h9;
    wait_clks(1);
    check_output("scl_oe_out_of_range", 32'(scl_oe), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
